uart_pack_fifo: RTL
===================

Name: uart_pack_fifo

Overview:
Parametrised circular byte FIFO for the UART TX/RX paths. It is the successor to the fixed 256-entry buffer. Adds true wrap-around, occupancy-based full/empty, independent write/read access widths (1 or 4 bytes per access), a programmable threshold, and sticky overflow/underflow flags. Sits between the TL-UL register interface and the UART shift engines.

Parameters:
DEPTH, 256, byte entries; power of two, 8..1024.
WR_BYTES, 4, bytes pushed per write access; 1 or 4.
RD_BYTES, 1, bytes popped per read access; 1 or 4.
AW, $clog2(DEPTH), pointer index width (derived, not overridden).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clr_i  in  1  synchronous flush: pointers, level, flags to reset state
we_i  in  1  write request
wdata_i  in  32  write data; byte 0 = wdata_i[7:0] enters first; unused upper bytes ignored when WR_BYTES=1
re_i  in  1  read (pop) request
rdata_o  out  32  head data, first-word-fall-through; oldest byte in [7:0]; upper bytes zero when RD_BYTES=1
full_o  out  1  free space < WR_BYTES
empty_o  out  1  level < RD_BYTES
level_o  out  AW+1  bytes currently stored, 0..DEPTH
thresh_i  in  AW+1  threshold level
thresh_o  out  1  level_o >= thresh_i (combinational)
ovf_o  out  1  sticky: write attempted while full
udf_o  out  1  sticky: read attempted while empty
peak_o  out  AW+1  maximum level since reset/clear (optional feature)

Behaviour:
- Reset (rst_ni low, async): wptr=rptr=0, level=0, ovf_o=udf_o=0, peak_o=0. Outputs: empty_o=1, full_o=0, rdata_o=0. Storage contents are not reset; no per-entry reset.
- Pointers are AW+1 bits with a wrap bit. Index = ptr[AW-1:0] and wraps modulo DEPTH. level = wptr - rptr (mod 2^(AW+1)).
- Write: on the clock edge with we_i & ~full_o, store WR_BYTES bytes at wptr..wptr+WR_BYTES-1 (each index modulo DEPTH), then wptr += WR_BYTES.
- Write while full: data dropped, wptr unchanged, ovf_o set.
- Read: rdata_o is combinational from rptr. It is valid whenever ~empty_o, and is 0 when empty_o.
  - On the edge with re_i & ~empty_o, rptr += RD_BYTES.
  - Read while empty: no pointer change, udf_o set.
- Simultaneous accepted read and write: both execute in the same cycle. full_o/empty_o are evaluated on the pre-edge level. level_new = level + WR_BYTES - RD_BYTES.
- A write is never visible on rdata_o in the same cycle. Latency write-to-read is 1 cycle.
- clr_i has priority over we_i/re_i in the same cycle: pointers, level, ovf_o, udf_o and peak_o clear; the request is ignored.
- Mixed widths (e.g. WR_BYTES=4, RD_BYTES=1):
  - full_o asserts at level > DEPTH-4.
  - empty_o asserts at level < RD_BYTES; with RD_BYTES=4, a partial tail of 1-3 bytes stays unreadable until it is topped up.
- All flags are derived from registered pointers. The only combinational input-to-output path is thresh_i->thresh_o.

Optional Feature:
- Macro: UART_PACK_FIFO_PEAK_EN.
- Defined: peak_o is a register updated each edge to max(peak_o, level_new) and cleared by reset/clr_i.
- Undefined: peak_o is tied to 0 and no peak register is inferred.

Decomposition:
- Package uart_fifo_pkg:
  - localparam BUS_BYTES=4.
  - typedef enum {ACC_BYTE=1, ACC_WORD=4} acc_width_e.
  - function clog2 wrapper for AW.
- Sub-module uart_fifo_ptr: AW+1-bit pointer with increment-by-step, clear and async reset. Instantiated twice (write and read).
- Storage, flags and packing logic live in the top module.

Test Plan:
- DEPTH=16, WR=4, RD=1. Reset, then write 0x44332211 -> level_o=4, empty_o=0; four pops return rdata_o[7:0]=0x11,0x22,0x33,0x44; then empty_o=1, rdata_o=0.
- DEPTH=16, WR=4. Write 4 words -> full_o=1, level_o=16; a 5th write is dropped, ovf_o=1, level_o stays 16; one pop -> level_o=15, full_o stays 1 (free 1<4).
- Wrap-around: fill 16, pop 12, write 3 words -> wptr wraps; 16 pops return the bytes in exact write order with no corruption.
- Simultaneous we_i&re_i at level 8 -> level_o=11 next cycle; pop on empty -> udf_o=1, level_o stays 0; clr_i asserted with we_i -> level_o=0, ovf_o=udf_o=0, write ignored.
- thresh_i=8: level goes 4->8 -> thresh_o rises in the same cycle level_o reaches 8. Assert rst_ni low mid-stream -> all outputs return to reset values immediately (async).
- With UART_PACK_FIFO_PEAK_EN: fill to 12, drain to 0 -> peak_o=12; clr_i -> peak_o=0. Without the macro -> peak_o=0 throughout.

Source files
------------

// File: rtl/uart_fifo_pkg.sv
// Shared constants and helpers for the UART packing byte FIFO.
package uart_fifo_pkg;

  localparam int BUS_BYTES = 4;

  typedef enum int {
    ACC_BYTE = 1,
    ACC_WORD = 4
  } acc_width_e;

  function automatic int clog2(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_fifo_ptr.sv
// Wrap-bit pointer: advances by STEP on inc_i, cleared by clr_i or async reset.
module uart_fifo_ptr #(
  parameter int PW   = 9,
  parameter int STEP = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_d;
  logic [PW-1:0] ptr_q;

  // Next pointer: clear wins over increment.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PW'(STEP);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/uart_pack_fifo.sv
// Circular byte FIFO with 1/4-byte write and read access widths and sticky error flags.
// Optional peak-level tracking is enabled by defining UART_PACK_FIFO_PEAK_EN.
module uart_pack_fifo
  import uart_fifo_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int WR_BYTES = 4,
  parameter int RD_BYTES = 1,
  parameter int AW       = clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [8*BUS_BYTES-1:0]   wdata_i,
  input  logic                     re_i,
  output logic [8*BUS_BYTES-1:0]   rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [AW:0]              level_o,
  input  logic [AW:0]              thresh_i,
  output logic                     thresh_o,
  output logic                     ovf_o,
  output logic                     udf_o,
  output logic [AW:0]              peak_o
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] WR_L    = (AW+1)'(WR_BYTES);
  localparam logic [AW:0] RD_L    = (AW+1)'(RD_BYTES);

  logic [7:0]             mem_q [DEPTH];
  logic [AW:0]            wptr_s;
  logic [AW:0]            rptr_s;
  logic [AW:0]            level_s;
  logic [AW:0]            free_s;
  logic [AW:0]            level_new_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   wr_acc_s;
  logic                   rd_acc_s;
  logic                   ovf_d;
  logic                   ovf_q;
  logic                   udf_d;
  logic                   udf_q;
  logic [8*BUS_BYTES-1:0] rdata_s;
  logic                   unused_s;

  uart_fifo_ptr #(.PW(AW+1), .STEP(WR_BYTES)) u_wptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (wr_acc_s),
    .ptr_o  (wptr_s)
  );

  uart_fifo_ptr #(.PW(AW+1), .STEP(RD_BYTES)) u_rptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (rd_acc_s),
    .ptr_o  (rptr_s)
  );

  // The wrap bit makes wptr - rptr the true occupancy, including the full case.
  assign level_s     = wptr_s - rptr_s;
  assign free_s      = DEPTH_L - level_s;
  assign full_s      = (free_s < WR_L);
  assign empty_s     = (level_s < RD_L);
  assign wr_acc_s    = we_i & ~full_s & ~clr_i;
  assign rd_acc_s    = re_i & ~empty_s & ~clr_i;
  assign level_new_s = level_s + (wr_acc_s ? WR_L : '0) - (rd_acc_s ? RD_L : '0);

  // Byte storage; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_acc_s) begin
      for (int i = 0; i < WR_BYTES; i++) begin
        mem_q[wptr_s[AW-1:0] + AW'(i)] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Head data falls through from the read pointer; zero while empty.
  always_comb begin
    rdata_s = '0;
    if (!empty_s) begin
      for (int j = 0; j < RD_BYTES; j++) begin
        rdata_s[8*j +: 8] = mem_q[rptr_s[AW-1:0] + AW'(j)];
      end
    end else begin
      rdata_s = '0;
    end
  end

  // Sticky error flags, flushed by clr_i.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      ovf_d = ovf_q | (we_i & full_s);
      udf_d = udf_q | (re_i & empty_s);
    end
  end

  // Flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

`ifdef UART_PACK_FIFO_PEAK_EN
  logic [AW:0] peak_d;
  logic [AW:0] peak_q;

  // High-water mark follows the post-edge level.
  always_comb begin
    peak_d = peak_q;
    if (clr_i) begin
      peak_d = '0;
    end else if (level_new_s > peak_q) begin
      peak_d = level_new_s;
    end else begin
      peak_d = peak_q;
    end
  end

  // Peak register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;
`else
  assign peak_o = '0;
`endif

  assign unused_s = ^{wdata_i, level_new_s};

  assign rdata_o  = rdata_s;
  assign full_o   = full_s;
  assign empty_o  = empty_s;
  assign level_o  = level_s;
  assign thresh_o = (level_s >= thresh_i);
  assign ovf_o    = ovf_q;
  assign udf_o    = udf_q;

endmodule
